// File: rtl/mem_port_arbiter.sv
// Purpose: shares one synchronous single-port SRAM between the CPU fetch and data ports.
// Latency: request sampled in IDLE at T, SRAM access at T+1, ack + rdata at T+3, IDLE at T+4.
// Backpressure: requesters hold req until their one-cycle ack; data wins ties unless fetch is starved.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   inst_req/inst_addr            - fetch request and byte address
//   inst_rdata/inst_ack           - fetched word (registered) and completion pulse
//   data_req/data_wr/data_wea     - data request, write select, byte enables
//   data_addr/data_wdata          - data byte address and write data
//   data_rdata/data_ack           - read word (registered) and completion pulse
//   sram_en/sram_wen/sram_addr    - SRAM enable, byte write enables, byte address
//   sram_wdata/sram_rdata         - SRAM write data, read data (valid cycle after sram_en)
module mem_port_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_rdata,
   output logic        inst_ack,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [3:0]  data_wea,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_ack,
   output logic        sram_en,
   output logic [3:0]  sram_wen,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      RESP = 2'd2,
      ACK  = 2'd3
   } state_t;

   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

   state_t     state;
   logic [2:0] starve_cnt;
   logic       gnt_inst;     // latched winner: 1 = fetch, 0 = data
   logic       lat_wr;       // latched data write flag
   logic       pick_inst;

   // Fetch wins only when data is absent or fetch has waited STARVE_MAX data grants.
   always_comb begin
      pick_inst = inst_req && (!data_req || (starve_cnt == STARVE_LIM));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         starve_cnt <= 3'd0;
         gnt_inst   <= 1'b0;
         lat_wr     <= 1'b0;
         inst_ack   <= 1'b0;
         data_ack   <= 1'b0;
         inst_rdata <= 32'h0;
         data_rdata <= 32'h0;
         sram_en    <= 1'b0;
         sram_wen   <= 4'h0;
         sram_addr  <= 32'h0;
         sram_wdata <= 32'h0;
      end else begin
         // Pulses and SRAM strobes default low; only the transitions below raise them.
         inst_ack <= 1'b0;
         data_ack <= 1'b0;
         sram_en  <= 1'b0;
         sram_wen <= 4'h0;
         case (state)
            IDLE: begin
               if (inst_req || data_req) begin
                  gnt_inst <= pick_inst;
                  sram_en  <= 1'b1;
                  if (pick_inst) begin
                     sram_addr  <= inst_addr;
                     lat_wr     <= 1'b0;
                     starve_cnt <= 3'd0;
                  end else begin
                     sram_addr  <= data_addr;
                     sram_wdata <= data_wdata;
                     lat_wr     <= data_wr;
                     sram_wen   <= data_wr ? data_wea : 4'h0;
                     // Count only data grants that actually made fetch wait.
                     if (!inst_req)
                        starve_cnt <= 3'd0;
                     else if (starve_cnt != STARVE_LIM)
                        starve_cnt <= starve_cnt + 3'd1;
                  end
                  state <= ACC;
               end
            end
            ACC: begin
               state <= RESP;
            end
            RESP: begin
               if (gnt_inst)
                  inst_rdata <= sram_rdata;
               else if (!lat_wr)
                  data_rdata <= sram_rdata;
               inst_ack <= gnt_inst;
               data_ack <= !gnt_inst;
               state    <= ACK;
            end
            ACK: begin
               // Requester still holds req here; returning to IDLE first avoids a re-grant.
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int SM = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        inst_ack;
   logic        data_req;
   logic        data_wr;
   logic [3:0]  data_wea;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_ack;
   logic        sram_en;
   logic [3:0]  sram_wen;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;

   mem_port_arbiter #(.STARVE_MAX(SM)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ack(inst_ack),
      .data_req(data_req), .data_wr(data_wr), .data_wea(data_wea), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ack(data_ack),
      .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
   endtask

   // ---------------- SRAM environment (driven by DUT pins) ----------------
   logic [31:0] sram_mem [256];
   always @(posedge clk) begin
      if (sram_en) begin
         sram_rdata <= sram_mem[sram_addr[9:2]];
         for (int b = 0; b < 4; b++)
            if (sram_wen[b]) sram_mem[sram_addr[9:2]][b*8 +: 8] = sram_wdata[b*8 +: 8];
      end
   end

   // ---------------- Transaction-level reference model ----------------
   // An access granted at cycle S uses the SRAM in S+1, reads in S+2, acks in S+3.
   logic [31:0] ref_mem [256];
   int          cyc = 0;
   bit          m_valid = 0;
   bit          m_busy  = 0;
   int          m_start = 0;
   bit          m_inst, m_wr;
   logic [3:0]  m_wea;
   logic [31:0] m_addr, m_wdata;
   int          m_cnt = 0;
   logic [31:0] exp_irdata = 0, exp_drdata = 0;

   always @(posedge clk) begin
      if (m_busy && cyc == m_start + 1 && !m_inst && m_wr)
         for (int b = 0; b < 4; b++)
            if (m_wea[b]) ref_mem[m_addr[9:2]][b*8 +: 8] = m_wdata[b*8 +: 8];
      if (m_busy && cyc == m_start + 2) begin
         if (m_inst) exp_irdata = ref_mem[m_addr[9:2]];
         else if (!m_wr) exp_drdata = ref_mem[m_addr[9:2]];
      end
      if (rst) begin
         m_valid = 1; m_busy = 0; m_cnt = 0; exp_irdata = 0; exp_drdata = 0;
      end else if (m_busy) begin
         if (cyc == m_start + 3) m_busy = 0;
      end else if (inst_req || data_req) begin
         m_busy  = 1;
         m_start = cyc;
         m_inst  = inst_req && (!data_req || m_cnt == SM);
         if (m_inst) begin
            m_addr = inst_addr; m_wr = 0; m_cnt = 0;
         end else begin
            m_addr = data_addr; m_wr = data_wr; m_wea = data_wea; m_wdata = data_wdata;
            m_cnt  = inst_req ? ((m_cnt < SM) ? m_cnt + 1 : SM) : 0;
         end
      end
      cyc++;
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         bit         e_en, e_iack, e_dack;
         logic [3:0] e_wen;
         e_en   = m_busy && cyc == m_start + 1;
         e_wen  = (e_en && !m_inst && m_wr) ? m_wea : 4'h0;
         e_iack = m_busy && cyc == m_start + 3 && m_inst;
         e_dack = m_busy && cyc == m_start + 3 && !m_inst;
         chk("sram_en", 32'(sram_en), 32'(e_en));
         chk("sram_wen", 32'(sram_wen), 32'(e_wen));
         chk("inst_ack", 32'(inst_ack), 32'(e_iack));
         chk("data_ack", 32'(data_ack), 32'(e_dack));
         chk("inst_rdata", inst_rdata, exp_irdata);
         chk("data_rdata", data_rdata, exp_drdata);
         if (e_en) chk("sram_addr", sram_addr, m_addr);
         if (e_wen != 4'h0) chk("sram_wdata", sram_wdata, m_wdata);
      end
   end

   // ---------------- Stimulus ----------------
   task automatic wait_ack(input bit is_inst, input int lim, output int at);
      at = -1;
      for (int k = 0; k < lim; k++) begin
         @(negedge clk);
         if (is_inst ? inst_ack : data_ack) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         n_checks++;
         $display("FAIL ack_timeout: no %s ack within %0d cycles, required one", is_inst ? "inst" : "data", lim);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) @(negedge clk);
   endtask

   function automatic logic [31:0] raddr();
      return $urandom() & 32'hFFFF_FFFC;
   endfunction

   int c0, at, at2, nd, extra, td, ti;
   bit got_i, resumed;

   initial begin
      for (int i = 0; i < 256; i++) begin
         sram_mem[i] = 32'h0;
         ref_mem[i]  = 32'h0;
      end
      sram_mem[0] = 32'h3C011234;  ref_mem[0] = 32'h3C011234;   // 0xBFC00000
      sram_mem[4] = 32'h11223344;  ref_mem[4] = 32'h11223344;   // 0x00000010
      sram_mem[16] = 32'hCAFEF00D; ref_mem[16] = 32'hCAFEF00D;  // 0x00000040
      rst = 1; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0;
      data_wea = 0; data_addr = 0; data_wdata = 0;
      idle(3);
      rst = 0;
      chk("reset_inst_rdata", inst_rdata, 32'h0);
      chk("reset_sram_en", 32'(sram_en), 32'h0);

      // Single fetch
      inst_req = 1; inst_addr = 32'hBFC00000; c0 = cyc;
      @(negedge clk);
      chk("fetch_sram_en", 32'(sram_en), 32'h1);
      chk("fetch_sram_addr", sram_addr, 32'hBFC00000);
      wait_ack(1, 6, at);
      chk("fetch_latency", 32'(at - c0), 32'd3);
      chk("fetch_rdata", inst_rdata, 32'h3C011234);
      chk("fetch_data_rdata", data_rdata, 32'h0);
      inst_req = 0;
      idle(2);

      // Byte write then read of the same word
      data_req = 1; data_wr = 1; data_wea = 4'b0010; data_addr = 32'h10; data_wdata = 32'h0000AB00;
      c0 = cyc;
      @(negedge clk);
      chk("bw_sram_wen", 32'(sram_wen), 32'b0010);
      wait_ack(0, 6, at);
      chk("bw_latency", 32'(at - c0), 32'd3);
      data_wr = 0;
      wait_ack(0, 7, at2);
      chk("b2b_spacing", 32'(at2 - at), 32'd4);
      chk("bw_readback", data_rdata, 32'h1122AB44);
      data_req = 0;
      idle(2);

      // Simultaneous requests with counter at 0
      inst_req = 1; inst_addr = 32'h40; data_req = 1; data_wr = 0; data_addr = 32'h10;
      td = -1; ti = -1;
      for (int k = 0; k < 20 && ti < 0; k++) begin
         @(negedge clk);
         if (data_ack) begin td = cyc; data_req = 0; end
         if (inst_ack) begin ti = cyc; inst_req = 0; end
      end
      chk("tie_data_first", 32'(td >= 0 && ti > td), 32'h1);
      chk("tie_inst_gap", 32'(ti - td), 32'd4);
      idle(2);

      // Starvation: continuous data traffic with a waiting fetch
      inst_req = 1; inst_addr = 32'hBFC00000; data_req = 1; data_wr = 0; data_addr = raddr();
      nd = 0; got_i = 0; resumed = 0;
      for (int k = 0; k < 80 && !resumed; k++) begin
         @(negedge clk);
         if (data_ack) begin
            if (got_i) resumed = 1; else nd++;
            data_addr = raddr();
         end
         if (inst_ack) begin got_i = 1; inst_req = 0; end
      end
      chk("starve_data_acks", 32'(nd), 32'(SM));
      chk("starve_resume", 32'(resumed), 32'h1);
      data_req = 0;
      idle(6);

      // Reset during RESP of a fetch
      inst_req = 1; inst_addr = 32'h40;
      idle(2);
      rst = 1;
      @(negedge clk);
      chk("rst_mid_no_ack", 32'(inst_ack), 32'h0);
      chk("rst_mid_rdata", inst_rdata, 32'h0);
      rst = 0; c0 = cyc;
      wait_ack(1, 6, at);
      chk("rst_restart_lat", 32'(at - c0), 32'd3);
      chk("rst_restart_rdata", inst_rdata, 32'hCAFEF00D);
      inst_req = 0;
      idle(2);

      // Early request drop during ACC of a write
      data_req = 1; data_wr = 1; data_wea = 4'hF; data_addr = 32'h20; data_wdata = 32'hDEADBEEF;
      @(negedge clk);
      data_req = 0;
      wait_ack(0, 5, at);
      extra = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (data_ack) extra++;
      end
      chk("drop_extra_acks", 32'(extra), 32'h0);
      chk("drop_write_landed", sram_mem[8], 32'hDEADBEEF);

      // Randomized traffic with occasional resets and early drops
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 399) == 0);
         if (inst_req && inst_ack) begin
            inst_req = 1'($urandom_range(0, 1));
            inst_addr = raddr();
         end else if (!inst_req && $urandom_range(0, 3) == 0) begin
            inst_req = 1; inst_addr = raddr();
         end
         if (data_req && data_ack) begin
            data_req = 1'($urandom_range(0, 1));
            data_wr = 1'($urandom_range(0, 1)); data_wea = 4'($urandom());
            data_addr = raddr(); data_wdata = $urandom();
         end else if (!data_req && $urandom_range(0, 2) == 0) begin
            data_req = 1;
            data_wr = 1'($urandom_range(0, 1)); data_wea = 4'($urandom());
            data_addr = raddr(); data_wdata = $urandom();
         end else if (data_req && $urandom_range(0, 63) == 0) begin
            data_req = 0;
         end
      end
      rst = 0; inst_req = 0; data_req = 0;
      idle(8);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
